matrix_mac_engine: RTL and testbench

- Parametrised successor to the single-core Matrix_TOP multiplier. Memory-mapped C = A x B engine on the 25 MHz peripheral bus.
- Generalised element width, maximum dimensions and number of parallel MAC lanes.
- Adds busy/error status, dimension checking, a done output and optional saturation.
- Sits behind the CPU data bus; the CPU loads A and B, starts the engine, polls status, then reads C.

---
 rtl/matrix_mac_engine_if.sv | 19 +
 rtl/matrix_mac_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mac_engine_if.sv
// Peripheral-bus bundle for the matrix MAC engine.
// The CPU side drives data/address/we; the engine returns read data and done.
interface matrix_mac_engine_if;
    logic [31:0] data;
    logic [12:0] address;
    logic        we;
    logic [31:0] o_data_rdt;
    logic        o_done;

    modport master (
        output data, address, we,
        input  o_data_rdt, o_done
    );

    modport slave (
        input  data, address, we,
        output o_data_rdt, o_done
    );
endinterface

// File: rtl/matrix_mac_engine.sv
// Memory-mapped C = A x B engine with LANES parallel MAC columns.
// Optional MATRIX_SAT_EN: saturate stored results and flag it in STATUS bit3.
module matrix_mac_engine #(
    parameter int DATA_W  = 16,
    parameter int ROW_MAX = 8,
    parameter int COL_MAX = 8,
    parameter int LANES   = 2
) (
    input logic                CLOCK_25,
    input logic                RESET_N,
    matrix_mac_engine_if.slave bus
);

    localparam int ACC_W = 2 * DATA_W + 5;
    localparam int RI_W  = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
    localparam int CI_W  = (COL_MAX > 1) ? $clog2(COL_MAX) : 1;
    localparam int RD    = 1 << RI_W;
    localparam int CD    = 1 << CI_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_STORE,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [7:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [7:0] i_q, i_d, j_q, j_d, t_q, t_d;
    logic busy_q, busy_d, done_q, done_d;
    logic error_q, error_d, sat_q, sat_d;
    logic [31:0] rdt_q, rdt_d;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];

    logic signed [DATA_W-1:0] a_mem [RD][CD];
    logic signed [DATA_W-1:0] b_mem [CD][CD];
    logic signed [DATA_W-1:0] c_mem [RD][CD];

    logic [2:0] region;
    logic [4:0] row, col;
    logic row_ok_a, row_ok_b, col_ok;
    logic wr_ctrl, wr_a, wr_b, size_bad;
    logic unused_data;

    logic [7:0]               lane_col [LANES];
    logic                     lane_en  [LANES];
    logic signed [2*DATA_W-1:0] prod   [LANES];
    logic signed [DATA_W-1:0] res      [LANES];
    logic                     lane_sat [LANES];
    logic                     sat_any;

    function automatic logic [31:0] sext(input logic signed [DATA_W-1:0] v);
        return 32'(v);
    endfunction

    assign region   = bus.address[12:10];
    assign row      = bus.address[9:5];
    assign col      = bus.address[4:0];
    assign row_ok_a = {1'b0, row} < 6'(ROW_MAX);
    assign row_ok_b = {1'b0, row} < 6'(COL_MAX);
    assign col_ok   = {1'b0, col} < 6'(COL_MAX);

    assign wr_ctrl = bus.we && !busy_q && region == 3'd0;
    assign wr_a = bus.we && !busy_q && region == 3'd1 && row_ok_a && col_ok;
    assign wr_b = bus.we && !busy_q && region == 3'd2 && row_ok_b && col_ok;

    assign size_bad = bus.data[7:0] == 8'd0 || bus.data[15:8] == 8'd0 ||
                      bus.data[23:16] == 8'd0 ||
                      bus.data[7:0] > 8'(ROW_MAX) ||
                      bus.data[15:8] > 8'(COL_MAX) ||
                      bus.data[23:16] > 8'(COL_MAX);

    assign unused_data = ^bus.data[30:24];

`ifdef MATRIX_SAT_EN
    localparam logic signed [ACC_W-1:0] SMAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    // One product per lane: A[i][t] is shared, B column offsets by lane.
    always_comb begin
        sat_any = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_col[l] = j_q + 8'(l);
            lane_en[l]  = lane_col[l] < n_q && lane_col[l] < 8'(COL_MAX);
            prod[l] = a_mem[i_q[RI_W-1:0]][t_q[CI_W-1:0]] *
                      b_mem[t_q[CI_W-1:0]][lane_col[l][CI_W-1:0]];
`ifdef MATRIX_SAT_EN
            lane_sat[l] = 1'b1;
            if (acc_q[l] > SMAX) begin
                res[l] = SMAX[DATA_W-1:0];
            end else if (acc_q[l] < SMIN) begin
                res[l] = SMIN[DATA_W-1:0];
            end else begin
                res[l] = acc_q[l][DATA_W-1:0];
                lane_sat[l] = 1'b0;
            end
`else
            res[l] = acc_q[l][DATA_W-1:0];
            lane_sat[l] = 1'b0;
`endif
            if (lane_sat[l] && lane_en[l]) begin
                sat_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        m_d = m_q;
        k_d = k_q;
        n_d = n_q;
        i_d = i_q;
        j_d = j_q;
        t_d = t_q;
        busy_d = busy_q;
        done_d = done_q;
        error_d = error_q;
        sat_d = sat_q;
        acc_d = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_ctrl) begin
                    m_d = bus.data[7:0];
                    k_d = bus.data[15:8];
                    n_d = bus.data[23:16];
                    error_d = 1'b0;
                    if (bus.data[31]) begin
                        done_d = 1'b0;
                        if (size_bad) begin
                            error_d = 1'b1;
                        end else begin
                            busy_d = 1'b1;
                            sat_d = 1'b0;
                            i_d = '0;
                            j_d = '0;
                            t_d = '0;
                            for (int l = 0; l < LANES; l++) acc_d[l] = '0;
                            state_d = S_MAC;
                        end
                    end
                end
            end
            S_MAC: begin
                for (int l = 0; l < LANES; l++) begin
                    acc_d[l] = acc_q[l] +
                        {{5{prod[l][2*DATA_W-1]}}, prod[l]};
                end
                if (t_q == k_q - 8'd1) begin
                    t_d = '0;
                    state_d = S_STORE;
                end else begin
                    t_d = t_q + 8'd1;
                end
            end
            S_STORE: begin
                sat_d = sat_q | sat_any;
                for (int l = 0; l < LANES; l++) acc_d[l] = '0;
                state_d = S_MAC;
                if (j_q + 8'(LANES) >= n_q) begin
                    j_d = '0;
                    i_d = i_q + 8'd1;
                    if (i_q + 8'd1 == m_q) begin
                        state_d = S_DONE;
                    end
                end else begin
                    j_d = j_q + 8'(LANES);
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // C reads are bounded by the latched run size, not just storage size.
    always_comb begin
        rdt_d = '0;
        case (region)
            3'd1: if (row_ok_a && col_ok)
                rdt_d = sext(a_mem[row[RI_W-1:0]][col[CI_W-1:0]]);
            3'd2: if (row_ok_b && col_ok)
                rdt_d = sext(b_mem[row[CI_W-1:0]][col[CI_W-1:0]]);
            3'd3: if (row_ok_a && col_ok &&
                      {3'b0, row} < m_q && {3'b0, col} < n_q)
                rdt_d = sext(c_mem[row[RI_W-1:0]][col[CI_W-1:0]]);
            3'd4: rdt_d = {28'd0, sat_q, error_q, busy_q, done_q};
            default: rdt_d = '0;
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (wr_a) begin
            a_mem[row[RI_W-1:0]][col[CI_W-1:0]] <= bus.data[DATA_W-1:0];
        end
        if (wr_b) begin
            b_mem[row[CI_W-1:0]][col[CI_W-1:0]] <= bus.data[DATA_W-1:0];
        end
        if (state_q == S_STORE) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_en[l]) begin
                    c_mem[i_q[RI_W-1:0]][lane_col[l][CI_W-1:0]] <= res[l];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            m_q <= '0;
            k_q <= '0;
            n_q <= '0;
            i_q <= '0;
            j_q <= '0;
            t_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            error_q <= 1'b0;
            sat_q <= 1'b0;
            rdt_q <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            state_q <= state_d;
            m_q <= m_d;
            k_q <= k_d;
            n_q <= n_d;
            i_q <= i_d;
            j_q <= j_d;
            t_q <= t_d;
            busy_q <= busy_d;
            done_q <= done_d;
            error_q <= error_d;
            sat_q <= sat_d;
            rdt_q <= rdt_d;
            for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
        end
    end

    assign bus.o_data_rdt = rdt_q;
    assign bus.o_done = done_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Scoreboard bench for matrix_mac_engine against a plain-arithmetic model.
// Honours MATRIX_SAT_EN in the model when the build defines it.
module tb_matrix_mac_engine;

    localparam int LN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    matrix_mac_engine_if bus ();

    matrix_mac_engine #(
        .DATA_W(16),
        .ROW_MAX(8),
        .COL_MAX(8),
        .LANES(LN)
    ) dut (
        .CLOCK_25(clk),
        .RESET_N(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    logic rd_now = 1'b0;
    logic [31:0] exp_q [$];
    string name_q [$];

    int ma [8][8];
    int mb [8][8];
    int mc [8][8];
    bit msat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rd_now) begin
            #1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty: got read, want none");
            end else begin
                check(name_q.pop_front(), bus.o_data_rdt, exp_q.pop_front());
            end
        end
    end

    function automatic int rv();
        if ($urandom_range(0, 3) == 0)
            return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 100)) - 50;
    endfunction

    // Expected C from the definition: full-precision dot products, then
    // either clamp or keep the low 16 bits as a signed value.
    function automatic void model(int m, int k, int n);
        longint s, v;
        msat = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                mc[r][c] = 0;
                if (r < m && c < n) begin
                    s = 0;
                    for (int t = 0; t < k; t++)
                        s += longint'(ma[r][t]) * longint'(mb[t][c]);
`ifdef MATRIX_SAT_EN
                    if (s > 32767) begin v = 32767; msat = 1; end
                    else if (s < -32768) begin v = -32768; msat = 1; end
                    else v = s;
`else
                    v = ((s % 65536) + 65536) % 65536;
                    if (v >= 32768) v -= 65536;
`endif
                    mc[r][c] = int'(v);
                end
            end
    endfunction

    function automatic logic [31:0] exp_status();
        return 32'(1 | (msat ? 8 : 0));
    endfunction

    task automatic wr(input logic [2:0] rg, input logic [4:0] r,
                      input logic [4:0] c, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1;
        bus.address = {rg, r, c};
        bus.data = d;
        @(posedge clk);
        #1 bus.we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] rg, input logic [4:0] r,
                      input logic [4:0] c, input logic [31:0] e,
                      input string nm);
        @(negedge clk);
        bus.we = 1'b0;
        bus.address = {rg, r, c};
        exp_q.push_back(e);
        name_q.push_back(nm);
        rd_now = 1'b1;
        @(posedge clk);
        #2 rd_now = 1'b0;
    endtask

    task automatic start(input int m, input int k, input int n,
                         input int hold);
        @(negedge clk);
        bus.we = 1'b1;
        bus.address = '0;
        bus.data = {1'b1, 7'd0, 8'(n), 8'(k), 8'(m)};
        t0 = cyc;
        repeat (hold) @(posedge clk);
        #1 bus.we = 1'b0;
    endtask

    task automatic wait_done(input int m, input int k, input int n,
                             input string nm);
        int w;
        int lat;
        w = 0;
        while (!bus.o_done && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        lat = m * ((n + LN - 1) / LN) * (k + 1) + 2;
        check({nm, "_latency"}, 32'(cyc - t0), 32'(lat));
    endtask

    task automatic load(input int m, input int k, input int n);
        for (int r = 0; r < m; r++)
            for (int t = 0; t < k; t++)
                wr(3'd1, 5'(r), 5'(t), 32'(ma[r][t]));
        for (int t = 0; t < k; t++)
            for (int c = 0; c < n; c++)
                wr(3'd2, 5'(t), 5'(c), 32'(mb[t][c]));
    endtask

    task automatic read_c(input int m, input int n, input string nm);
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++)
                rd(3'd3, 5'(r), 5'(c), 32'(mc[r][c]), {nm, "_c"});
    endtask

    initial begin
        int m, k, n;
        bus.we = 1'b0;
        bus.data = '0;
        bus.address = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdt", bus.o_data_rdt, 32'd0);
        check("reset_done", 32'(bus.o_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        rd(3'd4, 5'd0, 5'd0, 32'd0, "reset_status");

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                ma[r][c] = 3 * r + c + 1;
                mb[r][c] = 3 * r + c + 1;
            end
        load(3, 3, 3);
        model(3, 3, 3);
        check("t1_model_c00", 32'(mc[0][0]), 32'd30);
        start(3, 3, 3, 1);
        wait_done(3, 3, 3, "t1");
        check("t1_o_done", 32'(bus.o_done), 32'd1);
        rd(3'd4, 5'd0, 5'd0, exp_status(), "t1_status");
        read_c(3, 3, "t1");

        for (int r = 0; r < 2; r++)
            for (int t = 0; t < 5; t++) begin
                ma[r][t] = 5 * r + t + 1;
                mb[t][r] = 5 * r + t + 1;
            end
        load(2, 5, 2);
        model(2, 5, 2);
        start(2, 5, 2, 1);
        wait_done(2, 5, 2, "t2");
        read_c(2, 2, "t2");
        rd(3'd3, 5'd2, 5'd0, 32'd0, "t2_oob_row");
        rd(3'd3, 5'd0, 5'd2, 32'd0, "t2_oob_col");
        rd(3'd5, 5'd0, 5'd0, 32'd0, "region5");

        start(3, 3, 0, 1);
        rd(3'd4, 5'd0, 5'd0, 32'd4, "bad_status");
        check("bad_o_done", 32'(bus.o_done), 32'd0);
        repeat (4) @(posedge clk);
        rd(3'd4, 5'd0, 5'd0, 32'd4, "bad_status_later");
        start(2, 5, 2, 1);
        wait_done(2, 5, 2, "recover");
        rd(3'd4, 5'd0, 5'd0, exp_status(), "recover_status");
        read_c(2, 2, "recover");

        for (int r = 0; r < 3; r++)
            for (int t = 0; t < 4; t++) ma[r][t] = rv();
        for (int t = 0; t < 4; t++)
            for (int c = 0; c < 3; c++) mb[t][c] = rv();
        load(3, 4, 3);
        model(3, 4, 3);
        start(3, 4, 3, 3);
        wr(3'd1, 5'd0, 5'd0, 32'd99);
        wr(3'd0, 5'd0, 5'd0, 32'h8001_0101);
        rd(3'd4, 5'd0, 5'd0, 32'd2, "busy_status");
        wait_done(3, 4, 3, "busy");
        read_c(3, 3, "busy");
        rd(3'd1, 5'd0, 5'd0, 32'(ma[0][0]), "busy_a00");

        for (int r = 0; r < 4; r++)
            for (int t = 0; t < 4; t++) begin
                ma[r][t] = rv();
                mb[r][t] = rv();
            end
        load(4, 4, 4);
        model(4, 4, 4);
        start(4, 4, 4, 1);
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_done", 32'(bus.o_done), 32'd0);
        check("midrst_rdt", bus.o_data_rdt, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        rd(3'd4, 5'd0, 5'd0, 32'd0, "midrst_status");
        start(4, 4, 4, 1);
        wait_done(4, 4, 4, "restart");
        read_c(4, 4, "restart");

        ma[0][0] = 300;
        mb[0][0] = 200;
        load(1, 1, 1);
        model(1, 1, 1);
        start(1, 1, 1, 1);
        wait_done(1, 1, 1, "ovf_pos");
        read_c(1, 1, "ovf_pos");
        rd(3'd4, 5'd0, 5'd0, exp_status(), "ovf_pos_status");
        ma[0][0] = -300;
        load(1, 1, 1);
        model(1, 1, 1);
        start(1, 1, 1, 1);
        wait_done(1, 1, 1, "ovf_neg");
        read_c(1, 1, "ovf_neg");
        rd(3'd4, 5'd0, 5'd0, exp_status(), "ovf_neg_status");

        for (int it = 0; it < 6; it++) begin
            m = int'($urandom_range(1, 8));
            k = int'($urandom_range(1, 8));
            n = int'($urandom_range(1, 8));
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    ma[r][c] = rv();
                    mb[r][c] = rv();
                end
            load(m, k, n);
            model(m, k, n);
            start(m, k, n, 1);
            wait_done(m, k, n, "rand");
            read_c(m, n, "rand");
            rd(3'd4, 5'd0, 5'd0, exp_status(), "rand_status");
            if (m < 8) rd(3'd3, 5'(m), 5'd0, 32'd0, "rand_oob");
        end

        repeat (3) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, want 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
